quant_seq: RTL and testbench
============================

Name: quant_seq

Overview:
- Sequencer for the JPEG quantization stage: streams one 8x8 block of DCT coefficients, 64 x 16-bit packed two per 32-bit word, from the coefficient buffer.
- Fetches the matching reciprocal pair from the reciprocal table (luma or chroma), drives the two-lane combinational quantizer, and writes the quantized pairs into the destination buffer.
- Sits between the DCT output buffer and the entropy-coder input buffer in the jpeg accelerator. Started by the Wishbone control register logic.

Parameters:
- WORDS, 32, words per block (64 coefficients / 2 per word)
- AW, 5, word address width, log2(WORDS)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset
- start_i  in  1  start one block; sampled only in IDLE
- tbl_sel_i  in  1  reciprocal table select (0 luma, 1 chroma); latched on accepted start
- stall_i  in  1  freeze request (buffer port borrowed by CPU); freezes entire sequencer
- busy_o  out  1  block in progress
- done_o  out  1  one-cycle completion pulse
- src_addr_o  out  AW  coefficient buffer read address (sync RAM, 1-cycle latency)
- src_dat_i  in  32  coefficient pair {c_hi, c_lo}
- rec_addr_o  out  AW+1  reciprocal ROM address {tbl, idx} (sync, 1-cycle latency)
- rec_dat_i  in  32  reciprocal pair {r_hi, r_lo}
- q_x_o  out  32  quantizer operand pair
- q_rec1_o  out  16  reciprocal for upper lane
- q_rec2_o  out  16  reciprocal for lower lane
- q_res_i  in  32  quantizer result pair (combinational from q_* outputs)
- dst_we_o  out  1  destination buffer write strobe
- dst_addr_o  out  AW  destination word address
- dst_dat_o  out  32  destination write data

Behaviour:
- Clock and reset:
  - Single clock clk_i.
  - rst_i is synchronous, active-high.
  - On reset: state IDLE, counters 0, pipeline valids 0. All outputs 0: busy_o, done_o, dst_we_o, src_addr_o, rec_addr_o, dst_addr_o, dst_dat_o, q_*.
- States:
  - IDLE: start_i=1 -> latch tbl_sel_i, rd_idx=0, go to RUN. start_i is ignored in every other state.
  - RUN: src_addr_o = rd_idx, rec_addr_o = {tbl, rd_idx}. rd_idx increments each non-stalled cycle. After issuing rd_idx = WORDS-1, go to DRAIN.
  - DRAIN: no new reads. Wait until the final write has been issued, then go to DONE.
  - DONE: done_o=1 for exactly one cycle, then IDLE. A start in this cycle is ignored.
  - busy_o=1 in RUN and DRAIN only.
- Pipeline:
  - Stage 0: issue address k.
  - Stage 1: src_dat_i/rec_dat_i valid for k. q_x_o=src_dat_i, q_rec1_o=rec_dat_i[31:16], q_rec2_o=rec_dat_i[15:0]. q_res_i is registered into dst_dat_o, and k into dst_addr_o.
  - Stage 2: dst_we_o=1 for index k.
  - Lane order is preserved: upper coefficient with upper reciprocal.
  - The controller performs no arithmetic on the data.
- Latency with no stall:
  - start accepted at cycle T.
  - Reads at T+1..T+32.
  - Write of word k at T+3+k; the last write is at T+34.
  - done_o at T+35; busy_o high T+1..T+34.
  - Exactly WORDS writes per block, addresses strictly 0..WORDS-1 ascending.
- Stall:
  - stall_i=1 holds state, rd_idx, valids, src_addr_o, rec_addr_o, dst_addr_o, dst_dat_o. Held addresses keep sync-RAM outputs valid.
  - dst_we_o is forced 0 while stalled. A pending write is issued in the first non-stalled cycle.
  - Each stall cycle delays completion by exactly one cycle. No write is lost or duplicated.
  - stall_i in IDLE or DONE has no effect; done_o is not delayed.
- rst_i mid-block: immediate return to IDLE. No further writes, no done_o.
- tbl_sel_i changes after start have no effect until the next start.

Decomposition:
- Shared package jpeg_pkg:
  - state enum quant_seq_state_t {IDLE, RUN, DRAIN, DONE}
  - constant QBLK_WORDS=32
  - table-select constants TBL_LUMA=0, TBL_CHROMA=1
- No sub-module. The quantizer stays external, reached through the q_* ports, so the same datapath can be shared or swapped.

Test Plan:
- Basic block: tbl_sel=0, src word k = {16'(k), 16'(100+k)}, bench loops q_res_i = q_x_o. Required response:
  - 32 writes at T+3..T+34, dst_addr k, data equal to src word k.
  - rec_addr_o 0..31 issued.
  - done_o at T+35 only; busy_o T+1..T+34.
- Chroma select: tbl_sel=1 at start, dropped to 0 one cycle later -> rec_addr_o = 32+k for all 32 reads; q_rec1_o/q_rec2_o match the halves of ROM word 32+k.
- Stall: stall_i high for 3 cycles at T+10 and 1 cycle at T+34 -> still 32 writes in order with correct data, no we during stall, done_o at T+39.
- Start while busy: start_i pulsed at T+5 and on the done_o cycle -> ignored; exactly one block of 32 writes, then IDLE.
- Reset mid-block: rst_i at T+12 for one cycle -> from T+13 all outputs 0, no done_o. A fresh start afterwards completes normally with writes 0..31.
- Back-to-back: start asserted in the first IDLE cycle after done_o -> second block begins one cycle later, same timing as the basic block.

Source files
------------

// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared types and constants for the jpeg accelerator blocks
package jpeg_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} quant_seq_state_t;
  localparam int QBLK_WORDS = 32;
  localparam logic TBL_LUMA = 1'b0;
  localparam logic TBL_CHROMA = 1'b1;
endpackage

// File: rtl/quant_seq_if.sv
// quant_seq_if: buffer, reciprocal ROM and quantizer signals of the quantization sequencer
interface quant_seq_if #(parameter int AW = 5);
  logic [AW-1:0] src_addr_o;
  logic [31:0]   src_dat_i;
  logic [AW:0]   rec_addr_o;
  logic [31:0]   rec_dat_i;
  logic [31:0]   q_x_o;
  logic [15:0]   q_rec1_o;
  logic [15:0]   q_rec2_o;
  logic [31:0]   q_res_i;
  logic          dst_we_o;
  logic [AW-1:0] dst_addr_o;
  logic [31:0]   dst_dat_o;
  modport master (
    output src_addr_o, rec_addr_o, q_x_o, q_rec1_o, q_rec2_o, dst_we_o, dst_addr_o, dst_dat_o,
    input  src_dat_i, rec_dat_i, q_res_i
  );
  modport slave (
    input  src_addr_o, rec_addr_o, q_x_o, q_rec1_o, q_rec2_o, dst_we_o, dst_addr_o, dst_dat_o,
    output src_dat_i, rec_dat_i, q_res_i
  );
endinterface

// File: rtl/quant_seq.sv
// quant_seq: streams one coefficient block through the external quantizer into the destination buffer
module quant_seq
  import jpeg_pkg::*;
#(
  parameter int WORDS = QBLK_WORDS,
  parameter int AW = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic tbl_sel_i,
  input  logic stall_i,
  output logic busy_o,
  output logic done_o,
  quant_seq_if.master bus
);
  quant_seq_state_t state_q, state_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d, idx1_q, idx1_d, dst_addr_q, dst_addr_d;
  logic          tbl_q, tbl_d, v1_q, v1_d, v2_q, v2_d, adv;
  logic [31:0]   dst_dat_q, dst_dat_d;
  always_comb begin
    state_d = state_q;
    rd_idx_d = rd_idx_q;
    tbl_d = tbl_q;
    v1_d = v1_q;
    idx1_d = idx1_q;
    v2_d = v2_q;
    dst_addr_d = dst_addr_q;
    dst_dat_d = dst_dat_q;
    adv = !stall_i || state_q == IDLE || state_q == DONE;
    if (adv) begin
      v1_d = state_q == RUN;
      idx1_d = rd_idx_q;
      v2_d = v1_q;
      dst_dat_d = v1_q ? bus.q_res_i : dst_dat_q;
      dst_addr_d = v1_q ? idx1_q : dst_addr_q;
      case (state_q)
        IDLE: if (start_i) begin
          tbl_d = tbl_sel_i;
          rd_idx_d = '0;
          state_d = RUN;
        end
        RUN: begin
          rd_idx_d = rd_idx_q + AW'(1);
          state_d = rd_idx_q == AW'(WORDS - 1) ? DRAIN : RUN;
        end
        DRAIN: state_d = v2_q && !v1_q ? DONE : DRAIN;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rd_idx_q <= '0;
      tbl_q <= TBL_LUMA;
      v1_q <= 1'b0;
      idx1_q <= '0;
      v2_q <= 1'b0;
      dst_addr_q <= '0;
      dst_dat_q <= '0;
    end else begin
      state_q <= state_d;
      rd_idx_q <= rd_idx_d;
      tbl_q <= tbl_d;
      v1_q <= v1_d;
      idx1_q <= idx1_d;
      v2_q <= v2_d;
      dst_addr_q <= dst_addr_d;
      dst_dat_q <= dst_dat_d;
    end
  end
  // quantizer operands are forced to zero outside stage-1 so idle outputs stay quiet
  assign busy_o = state_q == RUN || state_q == DRAIN;
  assign done_o = state_q == DONE;
  assign bus.src_addr_o = rd_idx_q;
  assign bus.rec_addr_o = {tbl_q, rd_idx_q};
  assign bus.q_x_o = v1_q ? bus.src_dat_i : '0;
  assign bus.q_rec1_o = v1_q ? bus.rec_dat_i[31:16] : '0;
  assign bus.q_rec2_o = v1_q ? bus.rec_dat_i[15:0] : '0;
  assign bus.dst_we_o = v2_q && !stall_i;
  assign bus.dst_addr_o = dst_addr_q;
  assign bus.dst_dat_o = dst_dat_q;
endmodule

// File: tb/tb_quant_seq.sv
// tb_quant_seq: directed stimulus with a cycle-count model of the quantization sequencer
module tb_quant_seq;
  localparam int W = 32;
  logic clk = 0, rst = 1, start = 0, tbl_sel = 0, stall = 0;
  logic busy, done;
  int checks = 0, errors = 0, cyc = 0;
  logic [31:0] src_mem [W];
  logic [31:0] rec_mem [2*W];
  bit m_act = 0, m_tbl = 0, m_clean = 1;
  int m_cnt = 0, wr_cnt = 0;
  quant_seq_if #(.AW(5)) bus ();
  quant_seq #(.WORDS(W), .AW(5)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .tbl_sel_i(tbl_sel), .stall_i(stall),
    .busy_o(busy), .done_o(done), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // buffer port is borrowed during a stall, so the RAM output register is held
  always @(posedge clk) if (!stall) begin
    bus.src_dat_i <= src_mem[bus.src_addr_o];
    bus.rec_dat_i <= rec_mem[bus.rec_addr_o];
  end
  assign bus.q_res_i = bus.q_x_o;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask
  // m_cnt = non-stalled cycles completed since the accepted start
  always @(posedge clk) begin
    if (rst) begin
      m_act <= 0; m_cnt <= 0; m_tbl <= 0; m_clean <= 1;
    end else if (!m_act) begin
      if (start) begin m_act <= 1; m_cnt <= 0; m_tbl <= tbl_sel; m_clean <= 0; end
    end else if (m_cnt == W + 2) m_act <= 0;
    else m_cnt <= m_cnt + (stall ? 0 : 1);
  end
  always @(negedge clk) if (!rst) begin
    int n;
    bit we_e;
    n = m_cnt + (stall ? 0 : 1);
    we_e = m_act && !stall && m_cnt < W + 2 && n >= 3 && n <= W + 2;
    chk("busy", busy, m_act && m_cnt < W + 2);
    chk("done", done, m_act && m_cnt == W + 2);
    chk("dst_we", bus.dst_we_o, we_e);
    if (m_act && m_cnt == W + 2) chk("write_count", wr_cnt, W);
    if (we_e) begin
      chk("dst_addr", bus.dst_addr_o, n - 3);
      chk("dst_dat", bus.dst_dat_o, src_mem[n-3]);
    end
    if (m_act && !stall && m_cnt < W + 2 && n >= 1 && n <= W) begin
      chk("src_addr", bus.src_addr_o, n - 1);
      chk("rec_addr", bus.rec_addr_o, m_tbl * W + n - 1);
    end
    if (m_act && !stall && m_cnt < W + 2 && n >= 2 && n <= W + 1) begin
      chk("q_x", bus.q_x_o, src_mem[n-2]);
      chk("q_rec1", bus.q_rec1_o, rec_mem[m_tbl*W+n-2][31:16]);
      chk("q_rec2", bus.q_rec2_o, rec_mem[m_tbl*W+n-2][15:0]);
    end
    if (!m_act && m_clean) begin
      chk("idle_addr_dat", {bus.src_addr_o, bus.rec_addr_o, bus.dst_addr_o, bus.dst_dat_o}, 0);
      chk("idle_q", {bus.q_x_o, bus.q_rec1_o, bus.q_rec2_o}, 0);
    end
    wr_cnt = !m_act ? 0 : wr_cnt + (bus.dst_we_o ? 1 : 0);
  end
  task automatic wait_to(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask
  task automatic at_neg(input int c);
    wait_to(c);
    @(negedge clk);
  endtask
  task automatic fill(input int off);
    for (int k = 0; k < W; k++) src_mem[k] = {16'(k + off), 16'(100 + k + off)};
  endtask
  task automatic kick(input logic tsel, output int t);
    t = cyc;
    start = 1; tbl_sel = tsel;
    wait_to(t + 1);
    start = 0;
  endtask
  initial begin
    int t, t2;
    for (int a = 0; a < 2 * W; a++) rec_mem[a] = {16'(1000 + a), 16'(2000 + a)};
    fill(0);
    wait_to(3);
    rst = 0;
    wait_to(6);
    kick(0, t);
    at_neg(t + 1); chk("basic_busy_t1", busy, 1);
    at_neg(t + 3); chk("basic_first_we", bus.dst_we_o, 1);
    chk("basic_first_dat", bus.dst_dat_o, 32'h0000_0064);
    at_neg(t + 34); chk("basic_last_addr", bus.dst_addr_o, 31);
    chk("basic_last_dat", bus.dst_dat_o, 32'h001F_0083);
    at_neg(t + 35); chk("basic_done", done, 1);
    at_neg(t + 36); chk("basic_after", {busy, done}, 0);
    wait_to(t + 40);
    fill(3);
    kick(1, t);
    tbl_sel = 0;
    at_neg(t + 1); chk("chroma_rec_addr0", bus.rec_addr_o, 6'd32);
    at_neg(t + 2); chk("chroma_rec1", bus.q_rec1_o, 16'h0408);
    chk("chroma_rec2", bus.q_rec2_o, 16'h07F0);
    at_neg(t + 32); chk("chroma_rec_addr31", bus.rec_addr_o, 6'd63);
    wait_to(t + 40);
    fill(11);
    kick(0, t);
    wait_to(t + 10); stall = 1;
    wait_to(t + 13); stall = 0;
    wait_to(t + 34); stall = 1;
    wait_to(t + 35); stall = 0;
    at_neg(t + 38); chk("stall_done_early", done, 0);
    at_neg(t + 39); chk("stall_done", done, 1);
    wait_to(t + 42);
    kick(0, t);
    wait_to(t + 5); start = 1;
    wait_to(t + 6); start = 0;
    wait_to(t + 35); start = 1;
    wait_to(t + 36); start = 0;
    at_neg(t + 37); chk("ignored_start_idle", {busy, done}, 0);
    wait_to(t + 45);
    kick(0, t);
    wait_to(t + 12); rst = 1;
    wait_to(t + 13); rst = 0;
    at_neg(t + 13); chk("rst_mid_outs", {busy, done, bus.dst_we_o, bus.src_addr_o}, 0);
    wait_to(t + 50);
    fill(5);
    kick(0, t);
    at_neg(t + 35); chk("post_rst_done", done, 1);
    wait_to(t + 36);
    fill(7);
    kick(0, t2);
    at_neg(t2 + 3); chk("b2b_first_addr", {bus.dst_we_o, bus.dst_addr_o}, 6'h20);
    at_neg(t2 + 35); chk("b2b_done", done, 1);
    wait_to(t2 + 40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
